// File: rtl/vga_pkg.sv
// Shared timing constants, fetch FSM states and RGB565 -> RGB888 colour expansion.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package vga_pkg;

  localparam int H_ACT = 640;
  localparam int V_ACT = 480;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_FILL  = 2'd2
  } state_t;

  // Replicate the top bits of each field so full-scale maps to 8'hFF and zero to 8'h00.
  function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

endpackage

// File: rtl/pixel_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with occupancy count and single-cycle flush.
// Latency: a write is visible at the head on the cycle after it is written.
// Backpressure: none; the writer guarantees space, overflow is flagged by an assertion.
module pixel_fifo_fwft #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_dat,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_rd;
  logic             do_wr;

  assign do_rd  = rd_en && (count_q != '0) && !flush;
  assign do_wr  = wr_en && !flush;
  assign rd_dat = mem_q[rd_ptr_q];
  assign count  = count_q;
  assign empty  = (count_q == '0);

  // Pointer and occupancy update; flush wins over any concurrent push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_wr) - CW'(do_rd);
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, no reset needed since reads are qualified by count.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_dat;
  end

  // A push into a full FIFO without a simultaneous pop would lose data.
  always_ff @(posedge clk) begin
    if (!rst && do_wr) begin
      assert ((count_q != CW'(DEPTH)) || do_rd);
    end
  end

endmodule

// File: rtl/vga_pixel_fetch.sv
// Prefetches RGB565 frame-buffer words into a FWFT FIFO and presents them as RGB888 on pixel request.
// Latency: memory latency plus one cycle from read return to pixel available; pixel is combinational on request.
// Backpressure: reads held stable while iMem_Wait; issue throttled by FIFO space and in-flight limit.
module vga_pixel_fetch #(
  parameter int          H_ACT      = vga_pkg::H_ACT,
  parameter int          V_ACT      = vga_pkg::V_ACT,
  parameter logic [21:0] BASE_ADDR  = 22'd0,
  parameter int          FIFO_DEPTH = 16,
  parameter int          MAX_OUTST  = 8
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iRequest,
  input  logic        iVGA_VS,
  output logic [7:0]  oRed,
  output logic [7:0]  oGreen,
  output logic [7:0]  oBlue,
  output logic [21:0] oMem_Addr,
  output logic        oMem_Read,
  input  logic        iMem_Wait,
  input  logic        iMem_Valid,
  input  logic [15:0] iMem_Data,
  output logic        oUnderflow
);

  import vga_pkg::*;

  localparam int          OW    = $clog2(MAX_OUTST+1);
  localparam int          CW    = $clog2(FIFO_DEPTH+1);
  localparam logic [19:0] TOTAL = 20'(H_ACT*V_ACT);

  state_t         state_q, state_d;
  logic [18:0]    fetch_cnt_q, fetch_cnt_d;
  logic [OW-1:0]  outst_q, outst_d;
  logic [OW-1:0]  discard_q, discard_d;
  logic           underflow_q, underflow_d;

  logic [CW-1:0]  fifo_count;
  logic           fifo_empty;
  logic [15:0]    fifo_head;
  logic           fifo_flush;
  logic           fifo_push;
  logic           fifo_pop;
  logic           issue;
  logic           accept;
  logic           ret;

  pixel_fifo_fwft #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (iCLK),
    .rst    (iRST),
    .flush  (fifo_flush),
    .wr_en  (fifo_push),
    .wr_dat (iMem_Data),
    .rd_en  (fifo_pop),
    .rd_dat (fifo_head),
    .count  (fifo_count),
    .empty  (fifo_empty)
  );

  // Read issue: only while filling with VS high, never past the frame end, and only
  // when every in-flight read already has a FIFO slot reserved.
  always_comb begin
    issue = 1'b0;
    if ((state_q == ST_FILL) && iVGA_VS && ({1'b0, fetch_cnt_q} < TOTAL) &&
        ((32'(fifo_count) + 32'(outst_q)) < 32'(FIFO_DEPTH)) &&
        (32'(outst_q) < 32'(MAX_OUTST))) begin
      issue = 1'b1;
    end
  end

  assign accept     = issue && !iMem_Wait;
  // A return with nothing in flight can only be a leftover from before a reset; ignore it.
  assign ret        = iMem_Valid && (outst_q != '0);
  assign fifo_pop   = iRequest && !fifo_empty;
  assign oMem_Read  = issue;
  assign oMem_Addr  = BASE_ADDR + {3'b000, fetch_cnt_q};
  assign oUnderflow = underflow_q;
  assign {oRed, oGreen, oBlue} = fifo_pop ? rgb565_to_888(fifo_head) : 24'h000000;

  // Frame FSM plus in-flight bookkeeping: returns owed to an aborted frame are dropped.
  always_comb begin
    state_d     = state_q;
    fetch_cnt_d = fetch_cnt_q;
    outst_d     = outst_q + OW'(accept) - OW'(ret);
    discard_d   = discard_q;
    underflow_d = underflow_q;
    fifo_flush  = 1'b0;
    fifo_push   = 1'b0;

    case (state_q)
      ST_IDLE:  if (!iVGA_VS) state_d = ST_FLUSH;
      ST_FLUSH: if (iVGA_VS)  state_d = ST_FILL;
      ST_FILL:  if (!iVGA_VS) state_d = ST_FLUSH;
      default:  state_d = ST_IDLE;
    endcase

    if (accept) fetch_cnt_d = fetch_cnt_q + 19'd1;

    if (ret) begin
      if (discard_q != '0)              discard_d = discard_q - OW'(1);
      else if (state_q == ST_FILL)      fifo_push = 1'b1;
    end

    if (iRequest && fifo_empty) underflow_d = 1'b1;

    if (state_q == ST_FLUSH) begin
      fifo_flush  = 1'b1;
      fetch_cnt_d = '0;
      underflow_d = 1'b0;
      discard_d   = outst_d;
    end
  end

  // State registers.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q     <= ST_IDLE;
      fetch_cnt_q <= '0;
      outst_q     <= '0;
      discard_q   <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_cnt_q <= fetch_cnt_d;
      outst_q     <= outst_d;
      discard_q   <= discard_d;
      underflow_q <= underflow_d;
    end
  end

endmodule
